// File: rtl/reu_pkg.sv
// rtl/reu_pkg.sv - shared transfer-type and state encodings for the REU DMA engine
package reu_pkg;

  // Transfer types as written by the register block into the command register
  typedef enum logic [1:0] {
    STASH  = 2'b00,
    FETCH  = 2'b01,
    SWAP   = 2'b10,
    VERIFY = 2'b11
  } xfer_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    XFER  = 3'd2,
    SWAP2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int WAIT_W = 3;

endpackage

// File: rtl/reu_dma_if.sv
// rtl/reu_dma_if.sv - bus, RAM and register-block signal bundle for the REU DMA engine
interface reu_dma_if;

  // Command and status from/to the register block
  logic       Execute;
  logic [1:0] XferType;
  logic       Length1;
  logic       IncCA;
  logic       IncREUA;
  logic       DecLen;
  logic       XferEnd;
  logic       SetEndOfBlock;
  logic       SetVerifyErr;
  logic       Busy;

  // C64 expansion-port bus
  logic       BA;
  logic       nDMA;
  logic [7:0] C64DI;
  logic       C64RD;
  logic       C64WR;
  logic [7:0] C64DO;

  // REU RAM port
  logic [7:0] REUDI;
  logic       REURD;
  logic       REUWR;
  logic [7:0] REUDO;

  // DMA engine side
  modport master (
    input  Execute, XferType, Length1, BA, C64DI, REUDI,
    output nDMA, C64RD, C64WR, C64DO, REURD, REUWR, REUDO,
    output IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy
  );

  // Register block / bus / RAM side
  modport slave (
    output Execute, XferType, Length1, BA, C64DI, REUDI,
    input  nDMA, C64RD, C64WR, C64DO, REURD, REUWR, REUDO,
    input  IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr, Busy
  );

endinterface

// File: rtl/reu_dma.sv
// rtl/reu_dma.sv - REU DMA sequencer: stash, fetch, swap and verify between C64 bus and REU RAM
module reu_dma
  import reu_pkg::*;
#(
  parameter int START_WAIT = 1
) (
  input logic       PHI2,
  input logic       Reset,
  reu_dma_if.master bus
);

  state_t              r_state;
  state_t              w_next;
  xfer_t               r_type;
  logic [WAIT_W-1:0]   r_wait;
  logic [7:0]          r_hold_c;
  logic [7:0]          r_hold_r;

  logic       w_go;
  logic       w_done;
  logic       w_hold_ld;
  logic       w_c64rd;
  logic       w_c64wr;
  logic       w_reurd;
  logic       w_reuwr;
  logic [7:0] w_c64do;
  logic [7:0] w_reudo;
  logic       w_inc;
  logic       w_declen;
  logic       w_xend;
  logic       w_eob;
  logic       w_verr;

  // Bus cycles only happen when the port owns the bus; a pending reset suppresses every strobe
  assign w_go = bus.BA && !Reset;

  // State register, advanced on the PHI2 falling edge
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latched type, start-delay counter and swap hold registers
  always_ff @(negedge PHI2) begin
    if (Reset) begin
      r_type   <= STASH;
      r_wait   <= '0;
      r_hold_c <= '0;
      r_hold_r <= '0;
    end else begin
      if (r_state == IDLE && bus.Execute) begin
        r_type <= xfer_t'(bus.XferType);
        r_wait <= WAIT_W'(START_WAIT);
      end else if (r_state == START && bus.BA && r_wait != '0) begin
        r_wait <= r_wait - 3'd1;
      end
      if (w_hold_ld) begin
        r_hold_c <= bus.C64DI;
        r_hold_r <= bus.REUDI;
      end
    end
  end

  // Next state and per-cycle strobes, all combinational so the register block sees them this edge
  always_comb begin
    w_next    = r_state;
    w_done    = 1'b0;
    w_hold_ld = 1'b0;
    w_c64rd   = 1'b0;
    w_c64wr   = 1'b0;
    w_reurd   = 1'b0;
    w_reuwr   = 1'b0;
    w_c64do   = 8'h00;
    w_reudo   = 8'h00;
    w_inc     = 1'b0;
    w_declen  = 1'b0;
    w_xend    = 1'b0;
    w_eob     = 1'b0;
    w_verr    = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.Execute) w_next = START;
      end
      START: begin
        if (bus.BA && r_wait <= 3'd1) w_next = XFER;
      end
      XFER: begin
        if (w_go) begin
          unique case (r_type)
            STASH: begin
              w_c64rd = 1'b1;
              w_reuwr = 1'b1;
              w_reudo = bus.C64DI;
              w_inc   = 1'b1;
              w_done  = 1'b1;
            end
            FETCH: begin
              w_reurd = 1'b1;
              w_c64wr = 1'b1;
              w_c64do = bus.REUDI;
              w_inc   = 1'b1;
              w_done  = 1'b1;
            end
            SWAP: begin
              // Read both sides now, write them crossed in SWAP2
              w_c64rd   = 1'b1;
              w_reurd   = 1'b1;
              w_hold_ld = 1'b1;
              w_next    = SWAP2;
            end
            VERIFY: begin
              w_c64rd = 1'b1;
              w_reurd = 1'b1;
              w_inc   = 1'b1;
              if (bus.C64DI != bus.REUDI) begin
                // Mismatch ends the block; length is left alone
                w_verr = 1'b1;
                w_xend = 1'b1;
                w_eob  = bus.Length1;
                w_next = DONE;
              end else begin
                w_done = 1'b1;
              end
            end
          endcase
        end
      end
      SWAP2: begin
        if (w_go) begin
          w_c64wr = 1'b1;
          w_c64do = r_hold_r;
          w_reuwr = 1'b1;
          w_reudo = r_hold_c;
          w_inc   = 1'b1;
          w_done  = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    // A completed byte either counts down the length or, on the last byte, closes the block
    if (w_done) begin
      if (bus.Length1) begin
        w_eob  = 1'b1;
        w_xend = 1'b1;
        w_next = DONE;
      end else begin
        w_declen = 1'b1;
        w_next   = XFER;
      end
    end
  end

  assign bus.nDMA          = !(r_state == START || r_state == XFER || r_state == SWAP2);
  assign bus.Busy          = (r_state != IDLE);
  assign bus.C64RD         = w_c64rd;
  assign bus.C64WR         = w_c64wr;
  assign bus.C64DO         = w_c64do;
  assign bus.REURD         = w_reurd;
  assign bus.REUWR         = w_reuwr;
  assign bus.REUDO         = w_reudo;
  assign bus.IncCA         = w_inc;
  assign bus.IncREUA       = w_inc;
  assign bus.DecLen        = w_declen;
  assign bus.XferEnd       = w_xend;
  assign bus.SetEndOfBlock = w_eob;
  assign bus.SetVerifyErr  = w_verr;

endmodule

// File: tb/tb_reu_dma.sv
// tb/tb_reu_dma.sv - directed-vector bench for reu_dma (START_WAIT=1 and START_WAIT=3 instances)
module tb_reu_dma;

  // Strobe vector bit order:
  // {nDMA, Busy, C64RD, C64WR, REURD, REUWR, IncCA, IncREUA, DecLen, XferEnd, SetEndOfBlock, SetVerifyErr}
  localparam logic [11:0] V_IDLE   = 12'h800;
  localparam logic [11:0] V_WAIT   = 12'h400;
  localparam logic [11:0] V_DONE   = 12'hC00;
  localparam logic [11:0] V_ST_MID = 12'h678;
  localparam logic [11:0] V_ST_END = 12'h676;
  localparam logic [11:0] V_FE_MID = 12'h5B8;
  localparam logic [11:0] V_FE_END = 12'h5B6;
  localparam logic [11:0] V_SW_RD  = 12'h680;
  localparam logic [11:0] V_SW_MID = 12'h578;
  localparam logic [11:0] V_SW_END = 12'h576;
  localparam logic [11:0] V_VF_MID = 12'h6B8;
  localparam logic [11:0] V_VF_ERR = 12'h6B5;
  localparam logic [11:0] V_VF_EE  = 12'h6B7;

  logic PHI2 = 1'b1;
  logic rst1;
  logic rst3;
  logic sel3;
  int   n_cmp;
  int   n_bad;

  reu_dma_if bus1 ();
  reu_dma_if bus3 ();

  reu_dma #(.START_WAIT(1)) u_dut1 (.PHI2(PHI2), .Reset(rst1), .bus(bus1));
  reu_dma #(.START_WAIT(3)) u_dut3 (.PHI2(PHI2), .Reset(rst3), .bus(bus3));

  always #5 PHI2 = ~PHI2;

  function automatic logic [27:0] observed();
    if (sel3)
      return {bus3.nDMA, bus3.Busy, bus3.C64RD, bus3.C64WR, bus3.REURD, bus3.REUWR,
              bus3.IncCA, bus3.IncREUA, bus3.DecLen, bus3.XferEnd, bus3.SetEndOfBlock,
              bus3.SetVerifyErr, bus3.C64DO, bus3.REUDO};
    else
      return {bus1.nDMA, bus1.Busy, bus1.C64RD, bus1.C64WR, bus1.REURD, bus1.REUWR,
              bus1.IncCA, bus1.IncREUA, bus1.DecLen, bus1.XferEnd, bus1.SetEndOfBlock,
              bus1.SetVerifyErr, bus1.C64DO, bus1.REUDO};
  endfunction

  task automatic expect_eq(input string tag, input logic [27:0] act, input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One PHI2 cycle: drive inputs just after the falling edge, check outputs at the rising edge
  task automatic cyc(input string tag, input logic rst, input logic ex, input logic [1:0] ty,
                     input logic l1, input logic ba, input logic [7:0] cdi, input logic [7:0] rdi,
                     input logic [11:0] exp_s, input logic [7:0] exp_cdo, input logic [7:0] exp_rdo);
    @(negedge PHI2);
    #1;
    rst1 = rst;
    rst3 = sel3 ? rst : 1'b1;
    bus1.Execute = ex;  bus1.XferType = ty;  bus1.Length1 = l1;  bus1.BA = ba;
    bus1.C64DI = cdi;   bus1.REUDI = rdi;
    bus3.Execute = ex;  bus3.XferType = ty;  bus3.Length1 = l1;  bus3.BA = ba;
    bus3.C64DI = cdi;   bus3.REUDI = rdi;
    @(posedge PHI2);
    expect_eq(tag, observed(), {exp_s, exp_cdo, exp_rdo});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    sel3  = 1'b0;
    rst1  = 1'b1;
    rst3  = 1'b1;
    bus1.Execute = 1'b0; bus1.XferType = 2'b00; bus1.Length1 = 1'b0; bus1.BA = 1'b1;
    bus1.C64DI = 8'h00;  bus1.REUDI = 8'h00;
    bus3.Execute = 1'b0; bus3.XferType = 2'b00; bus3.Length1 = 1'b0; bus3.BA = 1'b1;
    bus3.C64DI = 8'h00;  bus3.REUDI = 8'h00;

    // Reset state
    cyc("reset",       1, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_IDLE, 8'h00, 8'h00);

    // Stash, length 3
    cyc("st_exec",     0, 1, 2'b00, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);
    cyc("st_ndma",     0, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_WAIT,   8'h00, 8'h00);
    cyc("st_b1",       0, 0, 2'b00, 0, 1, 8'h11, 8'hEE, V_ST_MID, 8'h00, 8'h11);
    cyc("st_b2",       0, 0, 2'b00, 0, 1, 8'h22, 8'hEE, V_ST_MID, 8'h00, 8'h22);
    cyc("st_b3",       0, 0, 2'b00, 1, 1, 8'h33, 8'hEE, V_ST_END, 8'h00, 8'h33);
    cyc("st_done",     0, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_DONE,   8'h00, 8'h00);
    cyc("st_idle",     0, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);

    // Fetch, length 2, three stalled cycles between bytes
    cyc("fe_exec",     0, 1, 2'b01, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);
    cyc("fe_start",    0, 0, 2'b01, 0, 1, 8'h00, 8'h00, V_WAIT,   8'h00, 8'h00);
    cyc("fe_b1",       0, 0, 2'b01, 0, 1, 8'hCC, 8'h44, V_FE_MID, 8'h44, 8'h00);
    for (int i = 0; i < 3; i++)
      cyc("fe_stall",  0, 0, 2'b01, 1, 0, 8'hCC, 8'h55, V_WAIT,   8'h00, 8'h00);
    cyc("fe_b2",       0, 0, 2'b01, 1, 1, 8'hCC, 8'h55, V_FE_END, 8'h55, 8'h00);
    cyc("fe_done",     0, 0, 2'b01, 0, 1, 8'h00, 8'h00, V_DONE,   8'h00, 8'h00);
    cyc("fe_idle",     0, 0, 2'b01, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);

    // Swap, length 2
    cyc("sw_exec",     0, 1, 2'b10, 0, 1, 8'h5A, 8'hA5, V_IDLE,   8'h00, 8'h00);
    cyc("sw_start",    0, 0, 2'b10, 0, 1, 8'h5A, 8'hA5, V_WAIT,   8'h00, 8'h00);
    cyc("sw_rd1",      0, 0, 2'b10, 0, 1, 8'h5A, 8'hA5, V_SW_RD,  8'h00, 8'h00);
    cyc("sw_wr1",      0, 0, 2'b10, 0, 1, 8'h00, 8'h00, V_SW_MID, 8'hA5, 8'h5A);
    cyc("sw_rd2",      0, 0, 2'b10, 1, 1, 8'h5A, 8'hA5, V_SW_RD,  8'h00, 8'h00);
    cyc("sw_wr2",      0, 0, 2'b10, 1, 1, 8'h00, 8'h00, V_SW_END, 8'hA5, 8'h5A);
    cyc("sw_done",     0, 0, 2'b10, 0, 1, 8'h00, 8'h00, V_DONE,   8'h00, 8'h00);
    cyc("sw_idle",     0, 0, 2'b10, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);

    // Verify, length 4, mismatch on byte 2
    cyc("vf_exec",     0, 1, 2'b11, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);
    cyc("vf_start",    0, 0, 2'b11, 0, 1, 8'h00, 8'h00, V_WAIT,   8'h00, 8'h00);
    cyc("vf_b1",       0, 0, 2'b11, 0, 1, 8'h77, 8'h77, V_VF_MID, 8'h00, 8'h00);
    cyc("vf_b2_err",   0, 0, 2'b11, 0, 1, 8'h78, 8'h77, V_VF_ERR, 8'h00, 8'h00);
    cyc("vf_done",     0, 0, 2'b11, 0, 1, 8'h77, 8'h77, V_DONE,   8'h00, 8'h00);
    cyc("vf_idle",     0, 0, 2'b11, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);

    // Verify, mismatch on the last byte: end-of-block and verify error together
    cyc("vl_exec",     0, 1, 2'b11, 1, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);
    cyc("vl_start",    0, 0, 2'b11, 1, 1, 8'h00, 8'h00, V_WAIT,   8'h00, 8'h00);
    cyc("vl_err_eob",  0, 0, 2'b11, 1, 1, 8'h01, 8'h02, V_VF_EE,  8'h00, 8'h00);
    cyc("vl_done",     0, 0, 2'b11, 0, 1, 8'h00, 8'h00, V_DONE,   8'h00, 8'h00);

    // Reset during SWAP2, then a fresh stash of length 1
    cyc("rs_idle",     0, 0, 2'b10, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);
    cyc("rs_exec",     0, 1, 2'b10, 0, 1, 8'h5A, 8'hA5, V_IDLE,   8'h00, 8'h00);
    cyc("rs_start",    0, 0, 2'b10, 0, 1, 8'h5A, 8'hA5, V_WAIT,   8'h00, 8'h00);
    cyc("rs_rd",       0, 0, 2'b10, 1, 1, 8'h5A, 8'hA5, V_SW_RD,  8'h00, 8'h00);
    cyc("rs_swap2",    1, 0, 2'b10, 1, 1, 8'h5A, 8'hA5, V_WAIT,   8'h00, 8'h00);
    cyc("rs_after",    0, 1, 2'b00, 1, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);
    cyc("rs_start2",   0, 0, 2'b00, 1, 1, 8'h00, 8'h00, V_WAIT,   8'h00, 8'h00);
    cyc("rs_b1",       0, 0, 2'b00, 1, 1, 8'h99, 8'h00, V_ST_END, 8'h00, 8'h99);
    cyc("rs_done",     0, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_DONE,   8'h00, 8'h00);

    // START_WAIT=3 instance: Execute in START, XFER and DONE is ignored
    sel3 = 1'b1;
    cyc("w3_exec",     0, 1, 2'b00, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);
    cyc("w3_start1",   0, 1, 2'b00, 0, 1, 8'h00, 8'h00, V_WAIT,   8'h00, 8'h00);
    cyc("w3_start2",   0, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_WAIT,   8'h00, 8'h00);
    cyc("w3_start3",   0, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_WAIT,   8'h00, 8'h00);
    cyc("w3_b1",       0, 1, 2'b01, 0, 1, 8'h10, 8'h00, V_ST_MID, 8'h00, 8'h10);
    cyc("w3_b2",       0, 0, 2'b00, 1, 1, 8'h20, 8'h00, V_ST_END, 8'h00, 8'h20);
    cyc("w3_done",     0, 1, 2'b01, 0, 1, 8'h00, 8'h00, V_DONE,   8'h00, 8'h00);
    cyc("w3_idle",     0, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);
    cyc("w3_stay",     0, 0, 2'b00, 0, 1, 8'h00, 8'h00, V_IDLE,   8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
